// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } xmit_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic LINE_LO = 1'b0;
  localparam logic LINE_HI = 1'b1;

  // Even parity is the XOR of the word; odd parity is its inverse.
  function automatic logic parity_bit(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell timer: counts OVERSAMPLE clocks per cell while running, pulses cell_end on the last one.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic run,
  output logic cell_end
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign cell_end = run && (cnt_reg == LAST_CNT);

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      cnt_reg <= '0;
    end else if (!run || cell_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_xmit_gen.sv
// UART transmitter: captures a word on accept and serialises start, data (LSB first),
// optional parity and stop bits, one bit cell per OVERSAMPLE clocks.
module uart_xmit_gen
  import uart_pkg::*;
#(
  parameter int WORD_LEN    = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic                xmitH,
  input  logic [WORD_LEN-1:0] xmit_dataH,
  output logic                xmit_readyH,
  output logic                uart_xmitH,
  output logic                xmit_doneH
);

  if (WORD_LEN < 5 || WORD_LEN > 9) begin : g_bad_word_len
    $error("uart_xmit_gen: WORD_LEN must be in 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 256) begin : g_bad_oversample
    $error("uart_xmit_gen: OVERSAMPLE must be in 4..256");
  end
  if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
    $error("uart_xmit_gen: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_xmit_gen: STOP_BITS must be 1 or 2");
  end

  localparam int BIT_W = $clog2(WORD_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_LEN - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  xmit_state_t         state_reg, state_next;
  logic [WORD_LEN-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic                stop_cnt_reg, stop_cnt_next;
  logic                par_reg, par_next;
  logic                line_reg, line_next;
  logic                done_reg, done_next;
  logic                cell_end;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .sys_clk  (sys_clk),
    .sys_rst_l(sys_rst_l),
    .run      (state_reg != IDLE),
    .cell_end (cell_end)
  );

  assign xmit_readyH = (state_reg == IDLE);
  assign uart_xmitH  = line_reg;
  assign xmit_doneH  = done_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      par_reg      <= 1'b0;
      line_reg     <= LINE_HI;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      par_reg      <= par_next;
      line_reg     <= line_next;
      done_reg     <= done_next;
    end
  end

  // The line register is loaded with the level of the cell being entered, so it
  // changes exactly on cell boundaries.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    par_next      = par_reg;
    line_next     = line_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        line_next = LINE_HI;
        if (xmitH) begin
          state_next    = START;
          shift_next    = xmit_dataH;
          par_next      = parity_bit(9'(xmit_dataH), PARITY_MODE == PAR_ODD);
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          line_next     = LINE_LO;
        end
      end
      START: begin
        if (cell_end) begin
          state_next = DATA;
          line_next  = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end
      DATA: begin
        if (cell_end) begin
          if (bit_cnt_reg == LAST_BIT) begin
            if (PARITY_MODE != PAR_NONE) begin
              state_next = PARITY;
              line_next  = par_reg;
            end else begin
              state_next = STOP;
              line_next  = LINE_HI;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            line_next    = shift_reg[0];
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (cell_end) begin
          state_next = STOP;
          line_next  = LINE_HI;
        end
      end
      STOP: begin
        if (cell_end) begin
          if (stop_cnt_reg == LAST_STOP) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = LINE_HI;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_xmit_gen.sv
// Directed bench for uart_xmit_gen: five configurations, each frame checked cycle by cycle
// against a hand-written cell string.
module tb_uart_xmit_gen;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       xmit [5];
  logic [7:0] d8 [4];
  logic [4:0] d5;
  logic       line [5];
  logic       rdy [5];
  logic       done [5];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_xmit_gen #(.WORD_LEN(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(clk), .sys_rst_l(rst_l), .xmitH(xmit[0]), .xmit_dataH(d8[0]),
    .xmit_readyH(rdy[0]), .uart_xmitH(line[0]), .xmit_doneH(done[0]));
  uart_xmit_gen #(.WORD_LEN(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .sys_clk(clk), .sys_rst_l(rst_l), .xmitH(xmit[1]), .xmit_dataH(d8[1]),
    .xmit_readyH(rdy[1]), .uart_xmitH(line[1]), .xmit_doneH(done[1]));
  uart_xmit_gen #(.WORD_LEN(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .sys_clk(clk), .sys_rst_l(rst_l), .xmitH(xmit[2]), .xmit_dataH(d8[2]),
    .xmit_readyH(rdy[2]), .uart_xmitH(line[2]), .xmit_doneH(done[2]));
  uart_xmit_gen #(.WORD_LEN(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .sys_clk(clk), .sys_rst_l(rst_l), .xmitH(xmit[3]), .xmit_dataH(d8[3]),
    .xmit_readyH(rdy[3]), .uart_xmitH(line[3]), .xmit_doneH(done[3]));
  uart_xmit_gen #(.WORD_LEN(5), .OVERSAMPLE(4), .PARITY_MODE(0), .STOP_BITS(1)) u_5n1 (
    .sys_clk(clk), .sys_rst_l(rst_l), .xmitH(xmit[4]), .xmit_dataH(d5),
    .xmit_readyH(rdy[4]), .uart_xmitH(line[4]), .xmit_doneH(done[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_data(input int idx, input logic [7:0] data);
    if (idx == 4) d5 = data[4:0];
    else d8[idx] = data;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  // cells holds the expected line level of each bit cell, first cell first.
  task automatic send_frame(input int idx, input int os, input logic [7:0] data,
                            input string cells, input bit hold);
    logic exp_line;
    set_data(idx, data);
    xmit[idx] = 1'b1;
    check($sformatf("ready_before_accept%0d", idx), 32'(rdy[idx]), 32'd1);
    @(posedge clk);
    for (int k = 0; k < cells.len() * os; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_data(idx, ~data);
        if (!hold) xmit[idx] = 1'b0;
      end
      exp_line = (cells[k / os] == "1");
      check($sformatf("frame%0d_%0h {line,done,ready} k=%0d", idx, data, k),
            32'({line[idx], done[idx], rdy[idx]}), 32'({exp_line, 2'b00}));
    end
    @(negedge clk);
    check($sformatf("done%0d_%0h {line,done,ready}", idx, data),
          32'({line[idx], done[idx], rdy[idx]}), 32'b111);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) xmit[i] = 1'b0;
    for (int i = 0; i < 4; i++) d8[i] = 8'h00;
    d5 = 5'h00;
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("reset_state%0d", i), 32'({line[i], done[i], rdy[i]}), 32'b101);
    rst_l = 1'b1;

    send_frame(0, 16, 8'hA5, "0101001011", 1'b0);
    send_frame(0, 16, 8'h3C, "0001111001", 1'b0);
    send_frame(1, 16, 8'h07, "01110000011", 1'b0);
    send_frame(1, 16, 8'h00, "00000000001", 1'b0);
    send_frame(2, 16, 8'h03, "01100000011", 1'b0);
    send_frame(2, 16, 8'h01, "01000000001", 1'b0);
    send_frame(3, 16, 8'h55, "01010101011", 1'b1);
    send_frame(3, 16, 8'hAA, "00101010111", 1'b0);
    send_frame(4, 4, 8'h1F, "0111111", 1'b0);
    send_frame(4, 4, 8'h0A, "0010101", 1'b0);

    // Abort a frame in the middle of data bit 3 (a zero bit of 0xA5).
    d8[0] = 8'hA5;
    xmit[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xmit[0] = 1'b0;
    repeat (70) @(negedge clk);
    check("line_in_data_bit3", 32'(line[0]), 32'd0);
    #2 rst_l = 1'b0;
    #1 check("async_reset_mid_frame", 32'({line[0], done[0], rdy[0]}), 32'b101);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check($sformatf("idle_after_abort k=%0d", k), 32'({line[0], done[0], rdy[0]}), 32'b101);
    end
    send_frame(0, 16, 8'hC3, "0110000111", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_xmit_gen.md
UART_XMIT_GEN -- requirements
Module: uart_xmit_gen

Interface
REQ-001 SHALL have parameter WORD_LEN, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning sys_clk cycles per bit cell, legal range 4..256.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd; value 3 is illegal and SHALL be rejected at elaboration.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop-bit count, legal values 1 or 2.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port sys_rst_l, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port xmitH, input, 1 bit: transmit request (valid).
REQ-008 SHALL have port xmit_dataH, input, WORD_LEN bits: word to send, LSB first.
REQ-009 SHALL have port xmit_readyH, output, 1 bit: high when a request can be accepted.
REQ-010 SHALL have port uart_xmitH, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port xmit_doneH, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-012 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_MODE != 0.
REQ-013 SHALL drive xmit_readyH high only in IDLE; a request is accepted on a cycle where xmitH and xmit_readyH are both high.
REQ-014 SHALL capture xmit_dataH into an internal shift register on the accept cycle; later changes to xmit_dataH have no effect on the frame.
REQ-015 SHALL move to START on the cycle after accept; the frame's first low on uart_xmitH appears on that cycle.
REQ-016 SHALL hold each bit cell for exactly OVERSAMPLE cycles, counted by a bit-cell counter that clears on every cell boundary.
REQ-017 SHALL send START (0), WORD_LEN data bits LSB first, the optional parity bit, then STOP_BITS stop bits (1).
REQ-018 SHALL compute parity over the captured word: even mode sends XOR of the bits; odd mode sends its inverse.
REQ-019 SHALL drive uart_xmitH from a register, glitch-free, and never X in any state.
REQ-020 SHALL count data bits 0..WORD_LEN-1 and leave DATA after the last cell ends; no wrap or extra cell.
REQ-021 SHALL pulse xmit_doneH for one cycle on the first IDLE cycle after the final stop cell; that cycle also has xmit_readyH high.
REQ-022 SHALL accept a request held high on the first IDLE cycle, so back-to-back frames have no idle gap beyond the stop bits.
REQ-023 SHALL ignore xmitH in any state other than IDLE.
REQ-024 SHALL give a total frame length of (1 + WORD_LEN + (PARITY_MODE!=0) + STOP_BITS) * OVERSAMPLE cycles.

Reset
REQ-025 SHALL on sys_rst_l low, immediately and asynchronously, set state IDLE, uart_xmitH 1, xmit_doneH 0, xmit_readyH 1, and counters and shift register to 0.
REQ-026 SHALL abort any frame in progress when reset is asserted mid-frame, with no xmit_doneH pulse for that frame.
REQ-027 SHALL accept a new request on the first clock edge after reset release.

Structure
REQ-028 SHALL take its state encoding, parity-mode constants and LO/HI line levels from shared package uart_pkg.
REQ-029 SHALL put the bit-cell counter in one sub-module, uart_bit_timer, parameterised by OVERSAMPLE, with a one-cycle cell_end output.

Verification
REQ-030 SHALL cover 8N1, OVERSAMPLE=16, send 0xA5: line bits are 0,1,0,1,0,0,1,0,1,1; each bit lasts 16 cycles; xmit_doneH pulses 161 cycles after accept.
REQ-031 SHALL cover even parity, send 0x07: parity bit 1, and 11 bit cells in the frame.
REQ-032 SHALL cover odd parity, send 0x03: parity bit 1; and send 0x01: parity bit 0.
REQ-033 SHALL cover STOP_BITS=2 with xmitH held high and 0x55 then 0xAA: stop high for 32 cycles, then the next start bit with no gap.
REQ-034 SHALL cover reset asserted in DATA bit 3: uart_xmitH is 1 immediately, xmit_doneH is never pulsed, and the next frame after release is correct.
REQ-035 SHALL cover WORD_LEN=5, OVERSAMPLE=4, send 0x1F: frame length 28 cycles, and xmit_dataH changes after accept do not alter the line.
